// File: rtl/nway_prefetch_cache_control.sv
// Control FSM for an N-way write-back, write-allocate cache with a hardware prefetch fill path.
// Optional feature macro CACHE_PF_STATS_EN adds saturating miss / prefetch-fill / prefetch-drop counters.
module nway_prefetch_cache_control #(
  parameter int WAYS = 2,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic                  mem_resp,
  input  logic                  pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  input  logic [WAYS-1:0]       hit_vec,
  input  logic [WAYS-1:0]       valid_vec,
  input  logic [WAYS-1:0]       dirty_vec,
  input  logic [WAY_W-1:0]      plru_victim,
  input  logic                  pf_req,
  output logic                  pf_ack,
  output logic                  pf_drop,
  output logic                  addr_sel,
  output logic [1:0]            pmem_addr_sel,
  output logic                  data_in_sel,
  output logic [WAY_W-1:0]      way_sel,
  output logic [2*WAYS-1:0]     wr_en_data_sel,
  output logic [WAYS-1:0]       ld_tag,
  output logic [WAYS-1:0]       ld_valid,
  output logic [WAYS-1:0]       ld_dirty,
  output logic                  valid_in,
  output logic                  dirty_in,
  output logic                  ld_lru
`ifdef CACHE_PF_STATS_EN
  ,
  output logic [15:0]           demand_miss_cnt,
  output logic [15:0]           pf_fill_cnt,
  output logic [15:0]           pf_drop_cnt
`endif
);

  typedef enum logic [2:0] {
    CHECK    = 3'd0,
    WB       = 3'd1,
    FILL     = 3'd2,
    PF_CHECK = 3'd3,
    PF_FILL  = 3'd4
  } state_t;

  state_t           state_q;
  state_t           next_state;
  logic [WAY_W-1:0] victim_q;
  logic [WAY_W-1:0] victim_s;
  logic [WAY_W-1:0] hit_idx;
  logic             hit_any;
  logic             victim_dirty;
  logic             demand;
  logic             latch_victim;

  function automatic logic [WAY_W-1:0] lowest_idx(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] r;
    r = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) r = WAY_W'(i);
    end
    return r;
  endfunction

  function automatic logic [WAYS-1:0] onehot(input logic [WAY_W-1:0] idx);
    logic [WAYS-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [2*WAYS-1:0] way_field(input logic [WAY_W-1:0] idx, input logic [1:0] code);
    logic [2*WAYS-1:0] r;
    r = '0;
    r[2*idx +: 2] = code;
    return r;
  endfunction

  assign hit_any      = |hit_vec;
  assign hit_idx      = lowest_idx(hit_vec);
  assign demand       = mem_read | mem_write;
  assign victim_dirty = valid_vec[victim_s] & dirty_vec[victim_s];

  // Replacement choice: an empty way beats the PLRU suggestion.
  always_comb begin
    if (|(~valid_vec)) begin
      victim_s = lowest_idx(~valid_vec);
    end else begin
      victim_s = plru_victim;
    end
  end

  // Next-state and combinational control outputs.
  always_comb begin
    next_state     = state_q;
    latch_victim   = 1'b0;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    pf_ack         = 1'b0;
    pf_drop        = 1'b0;
    addr_sel       = 1'b0;
    pmem_addr_sel  = 2'b00;
    data_in_sel    = 1'b0;
    way_sel        = '0;
    wr_en_data_sel = '0;
    ld_tag         = '0;
    ld_valid       = '0;
    ld_dirty       = '0;
    valid_in       = 1'b0;
    dirty_in       = 1'b0;
    ld_lru         = 1'b0;
    case (state_q)
      CHECK: begin
        if (demand) begin
          if (hit_any) begin
            mem_resp = 1'b1;
            way_sel  = hit_idx;
            ld_lru   = 1'b1;
            if (mem_write) begin
              wr_en_data_sel = way_field(hit_idx, 2'b10);
              data_in_sel    = 1'b1;
              dirty_in       = 1'b1;
              ld_dirty       = onehot(hit_idx);
            end else begin
              data_in_sel    = 1'b0;
            end
          end else begin
            latch_victim = 1'b1;
            next_state   = victim_dirty ? WB : FILL;
          end
        end else if (pf_req) begin
          next_state = PF_CHECK;
        end else begin
          next_state = CHECK;
        end
      end
      WB: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 2'b01;
        way_sel       = victim_q;
        if (pmem_resp) begin
          ld_dirty   = onehot(victim_q);
          next_state = FILL;
        end else begin
          next_state = WB;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          wr_en_data_sel = way_field(victim_q, 2'b01);
          ld_tag         = onehot(victim_q);
          ld_valid       = onehot(victim_q);
          ld_dirty       = onehot(victim_q);
          valid_in       = 1'b1;
          next_state     = CHECK;
        end else begin
          next_state     = FILL;
        end
      end
      PF_CHECK: begin
        addr_sel = 1'b1;
        // Prefetches never evict dirty data: a dirty victim drops the request.
        if (hit_any || victim_dirty) begin
          pf_ack     = 1'b1;
          pf_drop    = 1'b1;
          next_state = CHECK;
        end else begin
          latch_victim = 1'b1;
          next_state   = PF_FILL;
        end
      end
      PF_FILL: begin
        addr_sel      = 1'b1;
        pmem_read     = 1'b1;
        pmem_addr_sel = 2'b10;
        if (pmem_resp) begin
          wr_en_data_sel = way_field(victim_q, 2'b01);
          ld_tag         = onehot(victim_q);
          ld_valid       = onehot(victim_q);
          ld_dirty       = onehot(victim_q);
          valid_in       = 1'b1;
          pf_ack         = 1'b1;
          next_state     = CHECK;
        end else begin
          next_state     = PF_FILL;
        end
      end
      default: begin
        next_state = CHECK;
      end
    endcase
  end

  // State and latched victim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CHECK;
      victim_q <= '0;
    end else begin
      state_q <= next_state;
      if (latch_victim) begin
        victim_q <= victim_s;
      end else begin
        victim_q <= victim_q;
      end
    end
  end

`ifdef CACHE_PF_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      demand_miss_cnt <= 16'd0;
      pf_fill_cnt     <= 16'd0;
      pf_drop_cnt     <= 16'd0;
    end else begin
      if ((state_q == CHECK) && demand && !hit_any) demand_miss_cnt <= sat_inc(demand_miss_cnt);
      if ((state_q == PF_FILL) && pmem_resp) pf_fill_cnt <= sat_inc(pf_fill_cnt);
      if ((state_q == PF_CHECK) && (hit_any || victim_dirty)) pf_drop_cnt <= sat_inc(pf_drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_nway_prefetch_cache_control.sv
// Directed bench for nway_prefetch_cache_control (WAYS=4): scenario tasks derive expected per-cycle
// outputs from the cache rules and a single negedge process compares them against the DUT.
module tb_nway_prefetch_cache_control;

  typedef struct packed {
    logic       rst, mem_read, mem_write, pmem_resp, pf_req;
    logic [3:0] hit_vec, valid_vec, dirty_vec;
    logic [1:0] plru;
  } in_t;

  typedef struct packed {
    logic       mem_resp, pmem_read, pmem_write, pf_ack, pf_drop, addr_sel;
    logic [1:0] pmem_addr_sel;
    logic       data_in_sel;
    logic [1:0] way_sel;
    logic [7:0] wr_en_data_sel;
    logic [3:0] ld_tag, ld_valid, ld_dirty;
    logic       valid_in, dirty_in, ld_lru;
  } outs_t;

  logic clk = 1'b0;
  in_t  cur;
  outs_t exp_q[$];
  string lbl_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_miss = 0, exp_fill = 0, exp_drop = 0;

  logic       mem_resp, pmem_read, pmem_write, pf_ack, pf_drop, addr_sel, data_in_sel;
  logic       valid_in, dirty_in, ld_lru;
  logic [1:0] pmem_addr_sel, way_sel;
  logic [7:0] wr_en_data_sel;
  logic [3:0] ld_tag, ld_valid, ld_dirty;
`ifdef CACHE_PF_STATS_EN
  logic [15:0] demand_miss_cnt, pf_fill_cnt, pf_drop_cnt;
`endif

  always #5 clk = ~clk;

  nway_prefetch_cache_control #(.WAYS(4)) dut (
    .clk(clk), .rst(cur.rst),
    .mem_read(cur.mem_read), .mem_write(cur.mem_write), .mem_resp(mem_resp),
    .pmem_resp(cur.pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .hit_vec(cur.hit_vec), .valid_vec(cur.valid_vec), .dirty_vec(cur.dirty_vec),
    .plru_victim(cur.plru), .pf_req(cur.pf_req), .pf_ack(pf_ack), .pf_drop(pf_drop),
    .addr_sel(addr_sel), .pmem_addr_sel(pmem_addr_sel), .data_in_sel(data_in_sel),
    .way_sel(way_sel), .wr_en_data_sel(wr_en_data_sel),
    .ld_tag(ld_tag), .ld_valid(ld_valid), .ld_dirty(ld_dirty),
    .valid_in(valid_in), .dirty_in(dirty_in), .ld_lru(ld_lru)
`ifdef CACHE_PF_STATS_EN
    , .demand_miss_cnt(demand_miss_cnt), .pf_fill_cnt(pf_fill_cnt), .pf_drop_cnt(pf_drop_cnt)
`endif
  );

  // Model: replacement rule and per-way field helpers.
  function automatic logic [1:0] m_victim(input logic [3:0] valid, input logic [1:0] plru);
    for (int i = 0; i < 4; i++) begin
      if (!valid[i]) return 2'(i);
    end
    return plru;
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] w);
    logic [3:0] r;
    r = 4'd0;
    r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] fld(input logic [1:0] w, input logic [1:0] code);
    logic [7:0] r;
    r = 8'd0;
    r[2*w +: 2] = code;
    return r;
  endfunction

  function automatic outs_t hit_out(input logic [1:0] w, input logic wr);
    outs_t e;
    e = '0;
    e.mem_resp = 1'b1;
    e.way_sel  = w;
    e.ld_lru   = 1'b1;
    if (wr) begin
      e.wr_en_data_sel = fld(w, 2'b10);
      e.data_in_sel    = 1'b1;
      e.dirty_in       = 1'b1;
      e.ld_dirty       = oh(w);
    end
    return e;
  endfunction

  function automatic outs_t fill_loads(input outs_t base, input logic [1:0] w);
    outs_t e;
    e = base;
    e.wr_en_data_sel = fld(w, 2'b01);
    e.ld_tag   = oh(w);
    e.ld_valid = oh(w);
    e.ld_dirty = oh(w);
    e.valid_in = 1'b1;
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  task automatic step(input string lbl, input in_t i, input outs_t e);
    @(posedge clk);
    #1;
    cur = i;
    exp_q.push_back(e);
    lbl_q.push_back(lbl);
  endtask

  // Every driven cycle: compare all outputs against the model expectation.
  always @(negedge clk) begin
    outs_t got, e;
    string lbl;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      lbl = lbl_q.pop_front();
      got = '{mem_resp, pmem_read, pmem_write, pf_ack, pf_drop, addr_sel, pmem_addr_sel,
              data_in_sel, way_sel, wr_en_data_sel, ld_tag, ld_valid, ld_dirty,
              valid_in, dirty_in, ld_lru};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s t=%0t: got %h, expected %h", lbl, $time, got, e);
      end
    end
  end

  task automatic demand_miss(input string nm, input logic wr, input logic [3:0] valid,
                             input logic [3:0] dirty, input logic [1:0] plru,
                             input int wb_lat, input int fill_lat);
    in_t i;
    outs_t z, e;
    logic [1:0] v;
    v = m_victim(valid, plru);
    z = '0;
    i = '0;
    i.mem_read = !wr; i.mem_write = wr;
    i.valid_vec = valid; i.dirty_vec = dirty; i.plru = plru;
    step({nm, "_lookup"}, i, z);
    exp_miss++;
    if (valid[v] && dirty[v]) begin
      e = z; e.pmem_write = 1'b1; e.pmem_addr_sel = 2'b01; e.way_sel = v;
      for (int k = 0; k < wb_lat; k++) step({nm, "_wb"}, i, e);
      i.pmem_resp = 1'b1; e.ld_dirty = oh(v);
      step({nm, "_wb_done"}, i, e);
      i.pmem_resp = 1'b0;
    end
    e = z; e.pmem_read = 1'b1;
    for (int k = 0; k < fill_lat; k++) step({nm, "_fill"}, i, e);
    i.pmem_resp = 1'b1;
    step({nm, "_fill_done"}, i, fill_loads(e, v));
    i.pmem_resp = 1'b0; i.hit_vec = oh(v);
    step({nm, "_retry_hit"}, i, hit_out(v, wr));
    step({nm, "_idle"}, '0, z);
  endtask

  task automatic prefetch(input string nm, input logic [3:0] valid, input logic [3:0] dirty,
                          input logic [3:0] hit, input logic [1:0] plru,
                          input int fill_lat, input logic demand_mid);
    in_t i;
    outs_t z, e;
    logic [1:0] v;
    v = m_victim(valid, plru);
    z = '0;
    i = '0;
    i.pf_req = 1'b1; i.valid_vec = valid; i.dirty_vec = dirty; i.plru = plru;
    step({nm, "_idle_check"}, i, z);
    i.hit_vec = hit;
    e = z; e.addr_sel = 1'b1;
    if ((|hit) || (valid[v] && dirty[v])) begin
      e.pf_ack = 1'b1; e.pf_drop = 1'b1;
      step({nm, "_drop"}, i, e);
      exp_drop++;
      step({nm, "_idle"}, '0, z);
    end else begin
      step({nm, "_pf_check"}, i, e);
      i.hit_vec = 4'd0; i.mem_read = demand_mid;
      e.pmem_read = 1'b1; e.pmem_addr_sel = 2'b10;
      for (int k = 0; k < fill_lat; k++) step({nm, "_pf_fill"}, i, e);
      i.pmem_resp = 1'b1;
      e = fill_loads(e, v); e.pf_ack = 1'b1;
      step({nm, "_pf_done"}, i, e);
      exp_fill++;
      i.pmem_resp = 1'b0; i.pf_req = 1'b0;
      if (demand_mid) begin
        i.hit_vec = 4'b0001;
        step({nm, "_late_demand"}, i, hit_out(2'd0, 1'b0));
      end
      step({nm, "_idle"}, '0, z);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t   i;
    outs_t z, e;
    z = '0;
    cur = '0;
    #3 cur.rst = 1'b1;
    i = '0; i.rst = 1'b1;
    step("reset0", i, z);
    step("reset1", i, z);
    step("idle_after_reset", '0, z);

    // Hand-computed pins of the model.
    chk("pin_victim_1011", int'(m_victim(4'b1011, 2'd3)), 2);
    chk("pin_victim_plru", int'(m_victim(4'b1111, 2'd1)), 1);
    chk("pin_field_way1", int'(fld(2'd1, 2'b01)), 8'h04);
    chk("pin_onehot_way1", int'(oh(2'd1)), 4'b0010);

    // Read hit in way 2, write hit in way 0.
    i = '0; i.mem_read = 1'b1; i.hit_vec = 4'b0100; i.valid_vec = 4'hF;
    e = z; e.mem_resp = 1'b1; e.way_sel = 2'd2; e.ld_lru = 1'b1;
    step("read_hit_w2", i, e);
    i = '0; i.mem_write = 1'b1; i.hit_vec = 4'b0001; i.valid_vec = 4'hF;
    step("write_hit_w0", i, hit_out(2'd0, 1'b1));
    step("idle", '0, z);

    // Reset in the middle of a fill burst.
    i = '0; i.mem_read = 1'b1; i.valid_vec = 4'hF;
    step("rst_miss", i, z);
    e = z; e.pmem_read = 1'b1;
    step("rst_fill", i, e);
    i = '0; i.rst = 1'b1;
    step("rst_mid_burst", i, z);
    step("rst_release", '0, z);
    exp_miss = 0; exp_fill = 0; exp_drop = 0;

    demand_miss("dirty_miss", 1'b0, 4'b1111, 4'b0010, 2'd1, 2, 3);
    demand_miss("clean_miss_invalid", 1'b0, 4'b1011, 4'b1111, 2'd3, 0, 0);
    demand_miss("write_dirty_miss", 1'b1, 4'b1111, 4'b1111, 2'd3, 0, 1);

    prefetch("pf_clean", 4'b0111, 4'b0000, 4'b0000, 2'd0, 2, 1'b1);

    // Demand and prefetch in the same cycle: demand first, prefetch stays pending.
    i = '0; i.mem_read = 1'b1; i.pf_req = 1'b1; i.hit_vec = 4'b1000; i.valid_vec = 4'hF;
    step("demand_beats_pf", i, hit_out(2'd3, 1'b0));
    prefetch("pf_after_demand", 4'b1111, 4'b0000, 4'b0000, 2'd2, 0, 1'b0);

    prefetch("pf_drop_hit", 4'b1111, 4'b0000, 4'b0100, 2'd0, 0, 1'b0);
    prefetch("pf_drop_dirty", 4'b1111, 4'b1000, 4'b0000, 2'd3, 0, 1'b0);

    @(posedge clk); #1;
`ifdef CACHE_PF_STATS_EN
    chk("demand_miss_cnt", int'(demand_miss_cnt), exp_miss);
    chk("pf_fill_cnt", int'(pf_fill_cnt), exp_fill);
    chk("pf_drop_cnt", int'(pf_drop_cnt), exp_drop);
    force dut.demand_miss_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.demand_miss_cnt;
    demand_miss("sat_miss", 1'b0, 4'b1111, 4'b0000, 2'd0, 0, 0);
    @(posedge clk); #1;
    chk("demand_miss_cnt_saturated", int'(demand_miss_cnt), 16'hFFFF);
    chk("pf_fill_cnt_unchanged", int'(pf_fill_cnt), exp_fill);
`endif
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
